decryption_dispatcher: RTL and testbench
========================================

# decryption_dispatcher

Front-end stage of the decryption datapath, directly upstream of the caesar, scytale and zigzag decryption engines. Accepts the serial encrypted character stream, binds each message to the engine chosen by `select` at message start, and buffers characters in a FIFO. It forwards them one per cycle to the chosen engine, holding back while that engine reports `busy`, so input arriving during a decryption is not lost.

## Interface
- `D_WIDTH`, 8, character width
- `FIFO_DEPTH`, 64, buffered entries, power of two, at least MAX_NOF_CHARS+1
- `START_DECRYPTION_TOKEN`, 8'hFA, end-of-message / start-decryption marker
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `data_i`  in  D_WIDTH  incoming character
- `valid_i`  in  1  `data_i` qualifier
- `select`  in  2  engine select: 0 caesar, 1 scytale, 2 zigzag, 3 invalid
- `busy0_i`, `busy1_i`, `busy2_i`  in  1 each  busy from engine 0/1/2
- `ready_o`  out  1  FIFO can accept a character this cycle
- `overflow_o`  out  1  sticky: a character was dropped
- `data0_o`, `data1_o`, `data2_o`  out  D_WIDTH each  character to engine 0/1/2
- `valid0_o`, `valid1_o`, `valid2_o`  out  1 each  character qualifiers

## Operation
- **Reset values.** All outputs reset to 0, except `ready_o`, which is 1. Reset also clears FIFO pointers, count, `in_msg`, `sel_lock`, `guard` and the sticky flag. Asserting reset mid-message discards the buffered contents; no partial character is emitted afterwards.
- **Message binding.**
  - When `in_msg`=0 and `valid_i`=1, `select` is captured into `sel_lock` and `in_msg` is set.
  - Later characters of the same message use `sel_lock`; `select` changes are ignored.
  - Accepting the token clears `in_msg`.
- **Invalid select.** If `sel_lock`=3, or if `select`=3 is captured, the message is consumed and discarded up to and including its token, and is not stored. `overflow_o` is not set.
- **FIFO write.**
  - An entry is {tag[1:0], char}; the token is stored like any other character.
  - A write happens when `valid_i`=1 and `ready_o`=1.
  - If `valid_i`=1 and `ready_o`=0, the character is dropped and `overflow_o` is set.
  - `overflow_o` stays set until reset.
- **FIFO read.** The head entry pops when all of the following hold:
  - the FIFO is non-empty;
  - `busyN_i`=0 for the head's tag N;
  - `guard`=0.
- **Pop output.** On a pop, the next cycle has `dataN_o`=char and `validN_o`=1. All other valid outputs are 0, and non-selected data outputs are 0.
- **Token guard.** The engines register `busy` one cycle after seeing the token. Popping a token therefore sets `guard` for exactly one cycle, so no pop happens in the cycle before `busy` becomes visible.
- **Head-of-line blocking.** The head blocks the whole FIFO: a busy engine stalls following messages even when they target idle engines. Order is preserved.
- **FSM** (`in_msg` tracking): IDLE -> MSG on the first accepted char; MSG -> IDLE on the accepted token. A token arriving in IDLE is a one-character message.
- **Counting.** `count` is $clog2(FIFO_DEPTH)+1 bits. Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

## Timing
- **Latency.** A character sampled at edge E is, at the earliest, written at E and popped at E+1, so `validN_o` is high after edge E+1.
- **Throughput.** 1 char/cycle while the target engine is idle.
- **Ready.** `ready_o` = (`count` < FIFO_DEPTH), decoded from registered state.
- **Full.** When full with a simultaneous pop, `ready_o` is already 0, so the push is dropped. No write-through.
- **Empty.** Write and read never coincide on the same entry; an empty FIFO pops nothing that cycle.
- **Busy.** `busyN_i` is sampled at the same edge as the pop decision. When it falls, the first pop happens at that edge if the head targets N.
- **Reset.** Asynchronous assert clears the block immediately. Deassertion is synchronous to `clk` externally.

## Structure
- **Package `decryption_pkg`.** Holds D_WIDTH, START_DECRYPTION_TOKEN, the select encodings SEL_CAESAR=0, SEL_SCYTALE=1, SEL_ZIGZAG=2, SEL_INVALID=3, and the entry-width constant.
- **Sub-module `sync_fifo`.** Parameterised width/depth, with push/pop, full/empty and count. It has no knowledge of tags.
- **Top level.** Binding FSM, guard, drop logic and output register.

## Test plan
1. **Single message, zigzag.** `select`=2, chars "ABC" then 8'hFA, busy low. Expected: `data2_o` emits 41,42,43,FA on consecutive cycles, each starting one edge after input; `valid0_o`/`valid1_o` stay 0.
2. **Busy stall.** Message to caesar; raise `busy0_i` after the token for 10 cycles while a second caesar message streams in. Expected: no `valid0_o` during busy; the buffered characters emit back-to-back from the edge `busy0_i` falls, with no loss.
3. **Token guard.** Send token then char "X" to scytale, with `busy1_i` rising one cycle after the token. Expected: "X" is withheld by the guard and released only after `busy1_i` falls.
4. **Overflow.** Hold all busy high and send FIFO_DEPTH+3 chars. Expected: `ready_o` goes low after entry FIFO_DEPTH; 3 chars are dropped; `overflow_o`=1 and stays 1.
5. **Select change and invalid select.**
   - Flip `select` mid-message: all chars still go to the engine captured at message start.
   - A message with `select`=3: no valid output, `overflow_o` stays 0.
6. **Reset mid-stream.** Pulse `rst_n` low asynchronously with 5 chars buffered. Expected: all outputs 0 immediately, `ready_o`=1, and nothing emitted after release.

Source files
------------

// File: rtl/decryption_pkg.sv
// Shared constants and encodings for the decryption front-end.
// Select codes, token value and FIFO entry geometry.
package decryption_pkg;

  localparam int D_WIDTH = 8;
  localparam logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA;

  localparam int TAG_W   = 2;
  localparam int ENTRY_W = D_WIDTH + TAG_W;

  typedef enum logic [1:0] {
    SEL_CAESAR  = 2'd0,
    SEL_SCYTALE = 2'd1,
    SEL_ZIGZAG  = 2'd2,
    SEL_INVALID = 2'd3
  } sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MSG  = 1'b1
  } msg_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/decryption_dispatcher.sv
// Binds each message to an engine, buffers it, and forwards
// characters one per cycle while the target engine is idle.
module decryption_dispatcher #(
  parameter int D_WIDTH = decryption_pkg::D_WIDTH,
  parameter int FIFO_DEPTH = 64,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN =
    decryption_pkg::START_DECRYPTION_TOKEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         select,
  input  logic               busy0_i,
  input  logic               busy1_i,
  input  logic               busy2_i,
  output logic               ready_o,
  output logic               overflow_o,
  output logic [D_WIDTH-1:0] data0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid0_o,
  output logic               valid1_o,
  output logic               valid2_o
);

  import decryption_pkg::*;

  localparam int EW = D_WIDTH + TAG_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  msg_state_e state_q, state_d;
  sel_e       sel_lock_q, sel_lock_d;
  logic       guard_q, guard_d;
  logic       ovf_q, ovf_d;

  logic [D_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [2:0]         v_q, v_d;

  sel_e               eff_sel;
  logic               is_tok, discard, push, drop, accepted;
  logic [EW-1:0]      wr_entry, head;
  logic [1:0]         head_tag;
  logic [D_WIDTH-1:0] head_ch;
  logic               head_busy, pop;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;

  assign eff_sel  = (state_q == ST_MSG) ? sel_lock_q : sel_e'(select);
  assign is_tok   = (data_i == START_DECRYPTION_TOKEN);
  assign discard  = valid_i && (eff_sel == SEL_INVALID);
  assign push     = valid_i && !discard && ready_o;
  assign drop     = valid_i && !discard && fifo_full;
  assign accepted = discard || push;
  assign wr_entry = {eff_sel, data_i};

  assign ready_o  = (fifo_count < CW'(FIFO_DEPTH));

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_tag = head[EW-1 -: TAG_W];
  assign head_ch  = head[D_WIDTH-1:0];

  // Busy of the engine that owns the head entry.
  always_comb begin
    head_busy = 1'b0;
    unique case (head_tag)
      2'd0:    head_busy = busy0_i;
      2'd1:    head_busy = busy1_i;
      2'd2:    head_busy = busy2_i;
      default: head_busy = 1'b0;
    endcase
  end

  assign pop     = !fifo_empty && !head_busy && !guard_q;
  assign guard_d = pop && (head_ch == START_DECRYPTION_TOKEN);
  assign ovf_d   = ovf_q || drop;

  // Message binding: lock select on first char, release on token.
  always_comb begin
    state_d    = state_q;
    sel_lock_d = sel_lock_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accepted) begin
          sel_lock_d = sel_e'(select);
          state_d    = is_tok ? ST_IDLE : ST_MSG;
        end
      end
      ST_MSG: begin
        if (accepted && is_tok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Steer the popped character to its engine, zero elsewhere.
  always_comb begin
    d0_d = '0;
    d1_d = '0;
    d2_d = '0;
    v_d  = '0;
    if (pop) begin
      unique case (head_tag)
        2'd0: begin
          d0_d   = head_ch;
          v_d[0] = 1'b1;
        end
        2'd1: begin
          d1_d   = head_ch;
          v_d[1] = 1'b1;
        end
        2'd2: begin
          d2_d   = head_ch;
          v_d[2] = 1'b1;
        end
        default: v_d = '0;
      endcase
    end
  end

  // Control state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_lock_q <= SEL_CAESAR;
      guard_q    <= 1'b0;
      ovf_q      <= 1'b0;
      d0_q       <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      v_q        <= '0;
    end else begin
      state_q    <= state_d;
      sel_lock_q <= sel_lock_d;
      guard_q    <= guard_d;
      ovf_q      <= ovf_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      v_q        <= v_d;
    end
  end

  assign overflow_o = ovf_q;
  assign data0_o    = d0_q;
  assign data1_o    = d1_q;
  assign data2_o    = d2_q;
  assign valid0_o   = v_q[0];
  assign valid1_o   = v_q[1];
  assign valid2_o   = v_q[2];

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Directed bench for decryption_dispatcher.
// Emitted characters are logged with cycle stamps and compared.
module tb_decryption_dispatcher;

  localparam int DEPTH = 64;
  localparam logic [7:0] TOK = 8'hFA;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [1:0] select;
  logic       busy0_i, busy1_i, busy2_i;
  logic       ready_o, overflow_o;
  logic [7:0] data0_o, data1_o, data2_o;
  logic       valid0_o, valid1_o, valid2_o;

  decryption_dispatcher #(
    .D_WIDTH (8),
    .FIFO_DEPTH (DEPTH),
    .START_DECRYPTION_TOKEN (TOK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .select     (select),
    .busy0_i    (busy0_i),
    .busy1_i    (busy1_i),
    .busy2_i    (busy2_i),
    .ready_o    (ready_o),
    .overflow_o (overflow_o),
    .data0_o    (data0_o),
    .data1_o    (data1_o),
    .data2_o    (data2_o),
    .valid0_o   (valid0_o),
    .valid1_o   (valid1_o),
    .valid2_o   (valid2_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] eng;
    logic [7:0] ch;
  } ev_t;

  ev_t log_q[$];
  int  stray = 0;

  always @(negedge clk) begin
    if ((int'(valid0_o) + int'(valid1_o) + int'(valid2_o)) > 1)
      stray++;
    if (!valid0_o && data0_o != 8'h00) stray++;
    if (!valid1_o && data1_o != 8'h00) stray++;
    if (!valid2_o && data2_o != 8'h00) stray++;
    if (valid0_o) log_q.push_back('{cyc, 2'd0, data0_o});
    if (valid1_o) log_q.push_back('{cyc, 2'd1, data1_o});
    if (valid2_o) log_q.push_back('{cyc, 2'd2, data2_o});
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_ev(input string tag, input int idx,
                        input logic [1:0] e, input logic [7:0] c,
                        input int t);
    if (idx >= log_q.size()) begin
      check({tag, "_present"}, log_q.size(), idx + 1);
    end else begin
      check({tag, "_eng"}, log_q[idx].eng, e);
      check({tag, "_ch"}, log_q[idx].ch, c);
      if (t >= 0) check({tag, "_cyc"}, log_q[idx].cyc, t);
    end
  endtask

  task automatic put(input logic [1:0] s, input logic [7:0] c);
    select  = s;
    data_i  = c;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    valid_i = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, {valid0_o, valid1_o, valid2_o}, 3'b000);
    check({tag, "_data"}, {data0_o, data1_o, data2_o}, 24'h0);
    check({tag, "_ready"}, ready_o, 1'b1);
    check({tag, "_ovf"}, overflow_o, 1'b0);
  endtask

  logic [7:0] t1c [4] = '{8'h41, 8'h42, 8'h43, 8'hFA};
  logic [7:0] t2c [5] = '{8'h45, 8'h46, 8'h47, 8'h48, 8'hFA};
  logic [7:0] t5c [4] = '{8'h50, 8'h51, 8'h52, 8'hFA};
  int n, m;

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    select  = 2'd0;
    busy0_i = 1'b0;
    busy1_i = 1'b0;
    busy2_i = 1'b0;
    #1;
    check_quiet("rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single zigzag message
    log_q.delete();
    n = cyc;
    for (int i = 0; i < 4; i++) put(2'd2, t1c[i]);
    idle(4);
    check("t1_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) exp_ev("t1", i, 2'd2, t1c[i], n + 2 + i);

    // caesar busy stall with a second message streaming in
    log_q.delete();
    n = cyc;
    put(2'd0, 8'h44);
    put(2'd0, TOK);
    put(2'd0, t2c[0]);
    busy0_i = 1'b1;
    for (int i = 1; i < 5; i++) put(2'd0, t2c[i]);
    idle(6);
    busy0_i = 1'b0;
    m = cyc;
    idle(8);
    check("t2_count", log_q.size(), 7);
    exp_ev("t2_d", 0, 2'd0, 8'h44, n + 2);
    exp_ev("t2_tok", 1, 2'd0, TOK, n + 3);
    for (int i = 0; i < 5; i++) exp_ev("t2_b", 2 + i, 2'd0, t2c[i], m + 1 + i);

    // token guard on scytale
    log_q.delete();
    n = cyc;
    put(2'd1, TOK);
    put(2'd1, 8'h58);
    idle(1);
    busy1_i = 1'b1;
    idle(5);
    busy1_i = 1'b0;
    m = cyc;
    idle(3);
    check("t3_count", log_q.size(), 2);
    exp_ev("t3_tok", 0, 2'd1, TOK, n + 2);
    exp_ev("t3_x", 1, 2'd1, 8'h58, m + 1);
    put(2'd1, TOK);
    idle(4);

    // select flips mid-message are ignored
    log_q.delete();
    n = cyc;
    put(2'd2, t5c[0]);
    put(2'd0, t5c[1]);
    put(2'd1, t5c[2]);
    put(2'd0, t5c[3]);
    idle(4);
    check("t5a_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) exp_ev("t5a", i, 2'd2, t5c[i], n + 2 + i);

    // invalid select message is swallowed
    log_q.delete();
    put(2'd3, 8'h53);
    put(2'd0, 8'h54);
    put(2'd2, TOK);
    idle(3);
    check("t5b_none", log_q.size(), 0);
    check("t5b_ovf", overflow_o, 1'b0);
    put(2'd2, 8'h55);
    put(2'd1, TOK);
    idle(4);
    check("t5b_count", log_q.size(), 2);
    exp_ev("t5b_u", 0, 2'd2, 8'h55, -1);
    exp_ev("t5b_tok", 1, 2'd2, TOK, -1);

    // asynchronous reset with characters buffered
    busy0_i = 1'b1;
    for (int i = 0; i < 5; i++) put(2'd0, 8'h61 + 8'(i));
    valid_i = 1'b0;
    busy0_i = 1'b0;
    @(posedge clk);
    #1;
    check("t6_pre_valid", valid0_o, 1'b1);
    check("t6_pre_data", data0_o, 8'h61);
    #1 rst_n = 1'b0;
    #1;
    check_quiet("t6_rst");
    log_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    check("t6_after", log_q.size(), 0);

    // overflow with every engine busy
    busy0_i = 1'b1;
    busy1_i = 1'b1;
    busy2_i = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i == DEPTH - 1) check("t4_ready_hi", ready_o, 1'b1);
      if (i == DEPTH) begin
        check("t4_ready_lo", ready_o, 1'b0);
        check("t4_ovf_clear", overflow_o, 1'b0);
      end
      put(2'd0, 8'h10 + 8'(i));
    end
    idle(1);
    check("t4_ovf_set", overflow_o, 1'b1);
    log_q.delete();
    busy0_i = 1'b0;
    busy1_i = 1'b0;
    busy2_i = 1'b0;
    idle(DEPTH + 6);
    check("t4_count", log_q.size(), DEPTH);
    exp_ev("t4_first", 0, 2'd0, 8'h10, -1);
    exp_ev("t4_last", DEPTH - 1, 2'd0, 8'h10 + 8'(DEPTH - 1), -1);
    check("t4_ovf_sticky", overflow_o, 1'b1);
    check("t4_ready_back", ready_o, 1'b1);

    check("no_stray", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
